// File: rtl/tl_intersection_model.sv
// Road-side model of four vehicle queues driven by the controller's lights.
// Arrival visible one edge after the pulse; departures every DEPART_CYCLES permitted cycles.
// No backpressure: arrivals are always accepted, full queues flag ovf.
// Optional build macro TL_CONFLICT_CHK_EN adds the sticky illegal-light checker.
module tl_intersection_model #(
  parameter int CW            = 4,
  parameter int DEPART_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  input  logic          arr_a,
  input  logic          arr_al,
  input  logic          arr_b,
  input  logic          arr_bl,
  output logic          Ta,
  output logic          Tal,
  output logic          Tb,
  output logic          Tbl,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_al,
  output logic [CW-1:0] cnt_b,
  output logic [CW-1:0] cnt_bl,
  output logic [3:0]    ovf,
  output logic          conflict
);

  // Light encoding: 00 GREEN, 01 YELLOW, 10 LEFT, 11 RED (YELLOW permits nothing).
  localparam logic [1:0] GREEN = 2'b00;
  localparam logic [1:0] LEFT  = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [7:0]    T_LAST  = 8'(DEPART_CYCLES - 1);

  // Lane order everywhere: {bl, b, al, a}
  logic [3:0] arr;
  logic [3:0] perm;

  assign arr  = {arr_bl, arr_b, arr_al, arr_a};
  assign perm = {Lb == LEFT, Lb == GREEN, La == LEFT, La == GREEN};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [CW-1:0] cnt_q;
    logic [7:0]    timer_q;
    logic [0:0]    state_q;
    logic          ovf_q;
    logic          nz;
    logic          active;
    logic [7:0]    tcur;
    logic          dep;

    assign nz     = (cnt_q != '0);
    assign active = perm[i] && nz;
    // The timer only carries meaning while draining; an idle lane starts from zero,
    // so the first permitted cycle already counts toward the first departure.
    assign tcur   = (state_q == ST_DRAIN) ? timer_q : 8'd0;
    assign dep    = active && (tcur == T_LAST);

    // Departure timer and IDLE/DRAIN state; losing permission or emptying discards progress
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        timer_q <= 8'd0;
      end else if (active) begin
        state_q <= ST_DRAIN;
        timer_q <= dep ? 8'd0 : tcur + 8'd1;
      end else begin
        state_q <= ST_IDLE;
        timer_q <= 8'd0;
      end
    end

    // Queue depth update: +arr -dep, saturating at max with a sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (arr[i] && !dep) begin
        if (cnt_q == CNT_MAX) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (!arr[i] && dep) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign cnt_a  = g_lane[0].cnt_q;
  assign cnt_al = g_lane[1].cnt_q;
  assign cnt_b  = g_lane[2].cnt_q;
  assign cnt_bl = g_lane[3].cnt_q;

  // Sensors are decoded straight from the registered counts
  assign Ta  = g_lane[0].nz;
  assign Tal = g_lane[1].nz;
  assign Tb  = g_lane[2].nz;
  assign Tbl = g_lane[3].nz;

  assign ovf = {g_lane[3].ovf_q, g_lane[2].ovf_q, g_lane[1].ovf_q, g_lane[0].ovf_q};

`ifdef TL_CONFLICT_CHK_EN
  localparam logic [1:0] RED = 2'b11;

  // Sticky flag: both directions showing something other than RED is illegal
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict <= 1'b0;
    end else if ((La != RED) && (Lb != RED)) begin
      conflict <= 1'b1;
    end
  end
`else
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_tl_intersection_model.sv
// Directed bench for tl_intersection_model with CW=4, DEPART_CYCLES=3.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// Conflict expectation follows the TL_CONFLICT_CHK_EN build macro.
module tb_tl_intersection_model;

  localparam logic [1:0] GREEN = 2'b00;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] RED   = 2'b11;

`ifdef TL_CONFLICT_CHK_EN
  localparam int CONFLICT_EXP = 1;
`else
  localparam int CONFLICT_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] La, Lb;
  logic       arr_a, arr_al, arr_b, arr_bl;
  logic       Ta, Tal, Tb, Tbl;
  logic [3:0] cnt_a, cnt_al, cnt_b, cnt_bl;
  logic [3:0] ovf;
  logic       conflict;

  int n_vec = 0;
  int n_bad = 0;

  tl_intersection_model #(.CW(4), .DEPART_CYCLES(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .La       (La),
    .Lb       (Lb),
    .arr_a    (arr_a),
    .arr_al   (arr_al),
    .arr_b    (arr_b),
    .arr_bl   (arr_bl),
    .Ta       (Ta),
    .Tal      (Tal),
    .Tb       (Tb),
    .Tbl      (Tbl),
    .cnt_a    (cnt_a),
    .cnt_al   (cnt_al),
    .cnt_b    (cnt_b),
    .cnt_bl   (cnt_bl),
    .ovf      (ovf),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    La = RED; Lb = RED;
    arr_a = 1'b0; arr_al = 1'b0; arr_b = 1'b0; arr_bl = 1'b0;

    // Reset state
    #2;
    chk("rst_cnt_a", 32'(cnt_a), 0);
    chk("rst_sensors", 32'({Ta, Tal, Tb, Tbl}), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_conflict", 32'(conflict), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step(2);
    chk("idle_counts", 32'({cnt_a, cnt_al, cnt_b, cnt_bl}), 0);
    chk("idle_sensors", 32'({Ta, Tal, Tb, Tbl}), 0);
    chk("idle_ovf", 32'(ovf), 0);
    chk("idle_conflict", 32'(conflict), 0);

    // Three arrivals on A while RED, then drain under GREEN
    arr_a = 1'b1; step(1); arr_a = 1'b0;
    chk("a_first_arr_cnt", 32'(cnt_a), 1);
    chk("a_first_arr_Ta", 32'(Ta), 1);
    arr_a = 1'b1; step(2); arr_a = 1'b0;
    chk("a_fill_cnt", 32'(cnt_a), 3);
    step(1);
    chk("a_red_hold", 32'(cnt_a), 3);
    La = GREEN;
    step(2);
    chk("a_green_2", 32'(cnt_a), 3);
    step(1);
    chk("a_dep1", 32'(cnt_a), 2);
    step(2);
    chk("a_green_5", 32'(cnt_a), 2);
    step(1);
    chk("a_dep2", 32'(cnt_a), 1);
    step(3);
    chk("a_dep3", 32'(cnt_a), 0);
    chk("a_Ta_fall", 32'(Ta), 0);
    chk("a_no_conflict", 32'(conflict), 0);
    La = RED;

    // Interrupted GREEN discards the partial timer
    arr_a = 1'b1; step(1); arr_a = 1'b0;
    La = GREEN; step(2);
    chk("a_short_green", 32'(cnt_a), 1);
    La = RED; step(1);
    chk("a_red_gap", 32'(cnt_a), 1);
    La = GREEN; step(2);
    chk("a_restart_2", 32'(cnt_a), 1);
    step(1);
    chk("a_restart_dep", 32'(cnt_a), 0);
    La = RED;

    // Fill AL past capacity (16 arrivals) and BL to capacity (15 arrivals)
    arr_al = 1'b1; arr_bl = 1'b1;
    step(15);
    arr_bl = 1'b0;
    chk("al_at_max", 32'(cnt_al), 15);
    chk("ovf_before", 32'(ovf), 0);
    step(1);
    arr_al = 1'b0;
    chk("al_saturate", 32'(cnt_al), 15);
    chk("al_ovf", 32'(ovf), 32'h2);
    chk("bl_at_max", 32'(cnt_bl), 15);

    // AL under LEFT: arrival coincident with departure keeps it at max
    La = LEFT; step(2);
    arr_al = 1'b1; step(1); arr_al = 1'b0;
    chk("al_max_arr_dep", 32'(cnt_al), 15);
    step(2);
    chk("al_hold_after", 32'(cnt_al), 15);
    step(1);
    chk("al_next_dep", 32'(cnt_al), 14);
    chk("al_ovf_sticky", 32'(ovf), 32'h2);
    La = RED;

    // BL at max without prior overflow: coincident arrival must not set ovf
    Lb = LEFT; step(2);
    arr_bl = 1'b1; step(1); arr_bl = 1'b0;
    chk("bl_max_arr_dep", 32'(cnt_bl), 15);
    chk("bl_no_ovf", 32'(ovf), 32'h2);
    step(3);
    chk("bl_next_dep", 32'(cnt_bl), 14);
    Lb = RED;

    // Lane B: arrival and departure in the same cycle at count 2
    arr_b = 1'b1; step(2); arr_b = 1'b0;
    chk("b_fill", 32'(cnt_b), 2);
    Lb = GREEN; step(2);
    arr_b = 1'b1; step(1); arr_b = 1'b0;
    chk("b_arr_dep", 32'(cnt_b), 2);
    step(2);

    // Asynchronous reset mid-drain
    reset = 1'b1;
    #1;
    chk("mid_rst_counts", 32'({cnt_a, cnt_al, cnt_b, cnt_bl}), 0);
    chk("mid_rst_sensors", 32'({Ta, Tal, Tb, Tbl}), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_conflict", 32'(conflict), 0);
    Lb = RED;
    @(negedge clk);
    reset = 1'b0;
    step(1);
    chk("post_rst_cnt_b", 32'(cnt_b), 0);
    arr_b = 1'b1; step(1); arr_b = 1'b0;
    Lb = GREEN; step(2);
    chk("restart_b_2", 32'(cnt_b), 1);
    step(1);
    chk("restart_b_dep", 32'(cnt_b), 0);
    Lb = RED;
    step(1);
    chk("pre_conflict", 32'(conflict), 0);

    // Illegal light pair for one cycle
    La = GREEN; Lb = LEFT;
    step(1);
    La = RED; Lb = RED;
    chk("conflict_set", 32'(conflict), 32'(CONFLICT_EXP));
    step(2);
    chk("conflict_sticky", 32'(conflict), 32'(CONFLICT_EXP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
